// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array front end and PE array.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } skew_state_e;

    localparam int N_LANES_DEF    = 4;
    localparam int DATA_WIDTH_DEF = 8;

endpackage

// File: rtl/systolic_delay_line.sv
// Fixed-depth register chain, shifts every cycle.
module systolic_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < DEPTH; s++) begin
                pipe_q[s] <= '0;
            end
        end else begin
            pipe_q[0] <= d;
            for (int s = 1; s < DEPTH; s++) begin
                pipe_q[s] <= pipe_q[s-1];
            end
        end
    end

    assign q = pipe_q[DEPTH-1];

endmodule

// File: rtl/systolic_input_skewer.sv
// Skews input vectors diagonally so lane i reaches array row i i+1 cycles later.
module systolic_input_skewer
    import systolic_pkg::*;
#(
    parameter int N_LANES    = N_LANES_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_LANES*DATA_WIDTH-1:0] in_data,
    input  logic                          in_last,
    output logic [N_LANES*DATA_WIDTH-1:0] out_data,
    output logic [N_LANES-1:0]            out_lane_valid,
    output logic                          out_done,
    output logic                          busy
);

    localparam int CW = (N_LANES > 1) ? $clog2(N_LANES) : 1;

    skew_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          xfer;

    assign in_ready = (state_q != DRAIN);
    assign busy     = (state_q != IDLE);
    assign xfer     = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, STREAM: begin
                if (xfer) begin
                    cnt_d = '0;
                    if (in_last) begin
                        state_d = (N_LANES == 1) ? IDLE : DRAIN;
                    end else begin
                        state_d = STREAM;
                    end
                end
            end
            DRAIN: begin
                // Hold off the next tile until the last vector's head clears lane N-2.
                if (cnt_q == CW'(N_LANES - 2)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        logic [DATA_WIDTH:0] head_d;
        logic [DATA_WIDTH:0] tail_q;

        assign head_d[DATA_WIDTH]     = xfer;
        assign head_d[DATA_WIDTH-1:0] =
            xfer ? in_data[g*DATA_WIDTH +: DATA_WIDTH] : '0;

        systolic_delay_line #(
            .DEPTH (g + 1),
            .WIDTH (DATA_WIDTH + 1)
        ) u_line (
            .clk (clk),
            .rst (rst),
            .d   (head_d),
            .q   (tail_q)
        );

        assign out_lane_valid[g] = tail_q[DATA_WIDTH];
        assign out_data[g*DATA_WIDTH +: DATA_WIDTH] =
            tail_q[DATA_WIDTH] ? tail_q[DATA_WIDTH-1:0] : '0;
    end

    // The last flag rides alongside lane N-1 so done lines up with its element.
    systolic_delay_line #(
        .DEPTH (N_LANES),
        .WIDTH (1)
    ) u_last_line (
        .clk (clk),
        .rst (rst),
        .d   (xfer & in_last),
        .q   (out_done)
    );

endmodule

// File: tb/tb_systolic_input_skewer.sv
// Directed bench for systolic_input_skewer with 4 lanes of 8 bits.
module tb_systolic_input_skewer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_last;
    logic [31:0] in_data;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_lane_valid;
    logic        out_done;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic        sv [16];
    logic        sl [16];
    logic [31:0] sd [16];

    always #5 clk = ~clk;

    systolic_input_skewer #(
        .N_LANES    (4),
        .DATA_WIDTH (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_last        (in_last),
        .out_data       (out_data),
        .out_lane_valid (out_lane_valid),
        .out_done       (out_done),
        .busy           (busy)
    );

    task automatic chk(input string tag, input logic [35:0] obs,
                       input logic [35:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sched();
        for (int i = 0; i < 16; i++) begin
            sv[i] = 1'b0;
            sl[i] = 1'b0;
            sd[i] = '0;
        end
    endtask

    function automatic logic [35:0] model_out(input int k);
        logic [3:0]  v;
        logic [31:0] d;
        v = '0;
        d = '0;
        for (int i = 0; i < 4; i++) begin
            int s;
            s = k - i - 1;
            if (s >= 0 && s < 16 && sv[s]) begin
                v[i]        = 1'b1;
                d[i*8 +: 8] = sd[s][i*8 +: 8];
            end
        end
        return {v, d};
    endfunction

    function automatic logic model_done(input int k);
        int s;
        s = k - 4;
        if (s >= 0 && s < 16) return sv[s] & sl[s];
        return 1'b0;
    endfunction

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        tick();
        tick();
        chk("rst_data",  36'(out_data), 36'h0);
        chk("rst_valid", 36'(out_lane_valid), 36'h0);
        chk("rst_done",  36'(out_done), 36'h0);
        chk("rst_busy",  36'(busy), 36'h0);
        chk("rst_ready", 36'(in_ready), 36'h1);
        rst = 1'b0;
        tick();

        // single vector with last
        in_valid = 1'b1;
        in_data  = 32'h44332211;
        in_last  = 1'b1;
        chk("single_ready_t0", 36'(in_ready), 36'h1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        for (int k = 1; k <= 4; k++) begin
            logic [31:0] m;
            m = 32'hFF << (8 * (k - 1));
            chk("single_data",  36'(out_data), 36'(32'h44332211 & m));
            chk("single_valid", 36'(out_lane_valid), 36'(4'b0001 << (k - 1)));
            chk("single_ready", 36'(in_ready), 36'(k == 4));
            chk("single_done",  36'(out_done), 36'(k == 4));
            tick();
        end
        chk("single_done_t5",  36'(out_done), 36'h0);
        chk("single_valid_t5", 36'(out_lane_valid), 36'h0);
        chk("single_idle_t5",  36'(busy), 36'h0);

        // three back-to-back vectors
        in_valid = 1'b1;
        in_last  = 1'b0;
        in_data  = 32'h0d0c0b0a;
        tick();
        chk("b2b_ready_t1", 36'(in_ready), 36'h1);
        chk("b2b_busy_t1",  36'(busy), 36'h1);
        in_data = 32'h1d1c1b1a;
        tick();
        in_data = 32'h2d2c2b2a;
        in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        chk("b2b_lane2_t3", 36'({out_lane_valid[2], out_data[23:16]}), 36'h10c);
        chk("b2b_ready_t3", 36'(in_ready), 36'h0);
        tick();
        chk("b2b_lane2_t4", 36'({out_lane_valid[2], out_data[23:16]}), 36'h11c);
        chk("b2b_lane3_t4", 36'({out_lane_valid[3], out_data[31:24]}), 36'h10d);
        chk("b2b_done_t4",  36'(out_done), 36'h0);
        tick();
        chk("b2b_lane2_t5", 36'({out_lane_valid[2], out_data[23:16]}), 36'h12c);
        chk("b2b_lane3_t5", 36'({out_lane_valid[3], out_data[31:24]}), 36'h11d);
        chk("b2b_done_t5",  36'(out_done), 36'h0);
        tick();
        chk("b2b_lane3_t6", 36'({out_lane_valid[3], out_data[31:24]}), 36'h12d);
        chk("b2b_done_t6",  36'(out_done), 36'h1);
        chk("b2b_ready_t6", 36'(in_ready), 36'h1);
        tick();

        // vector, bubble, last vector
        clear_sched();
        sv[0] = 1'b1; sd[0] = 32'h04030201;
        sv[2] = 1'b1; sd[2] = 32'h08070605; sl[2] = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            in_valid = sv[k];
            in_data  = sv[k] ? sd[k] : '0;
            in_last  = sl[k];
            if (k > 0) begin
                chk("bubble_lanes", {out_lane_valid, out_data}, model_out(k));
                chk("bubble_done",  36'(out_done), 36'(model_done(k)));
            end
            tick();
        end

        // reset mid-tile
        in_valid = 1'b1;
        in_last  = 1'b0;
        in_data  = 32'haaaaaaaa;
        tick();
        in_data = 32'hbbbbbbbb;
        tick();
        in_data = 32'hcccccccc;
        in_last = 1'b1;
        rst     = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        chk("midrst_valid", 36'(out_lane_valid), 36'h0);
        chk("midrst_data",  36'(out_data), 36'h0);
        chk("midrst_busy",  36'(busy), 36'h0);
        chk("midrst_ready", 36'(in_ready), 36'h1);
        for (int k = 0; k < 6; k++) begin
            chk("midrst_nodone", 36'({out_done, out_lane_valid}), 36'h0);
            tick();
        end

        // tile X then tile Y offered while draining
        clear_sched();
        sv[0] = 1'b1; sd[0] = 32'h34333231; sl[0] = 1'b1;
        sv[4] = 1'b1; sd[4] = 32'h44434241;
        sv[5] = 1'b1; sd[5] = 32'h54535251; sl[5] = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            logic exp_ready;
            exp_ready = !(k >= 1 && k <= 3) && !(k >= 6 && k <= 8);
            in_valid = (k <= 5);
            in_data  = (k == 0) ? sd[0] : (k <= 4) ? sd[4] :
                       (k == 5) ? sd[5] : 32'h0;
            in_last  = (k == 0) || (k == 5);
            chk("overlap_ready", 36'(in_ready), 36'(exp_ready));
            if (k > 0) begin
                chk("overlap_lanes", {out_lane_valid, out_data}, model_out(k));
                chk("overlap_done",  36'(out_done), 36'(model_done(k)));
            end
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/systolic_input_skewer.md
SYSTOLIC_INPUT_SKEWER -- requirements
Module: systolic_input_skewer

Interface
REQ-001 Parameter N_LANES, default 4, number of array rows fed (one lane per row).
REQ-002 Parameter DATA_WIDTH, default 8, width of each lane element.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream vector valid.
REQ-006 in_ready  output  1  skewer accepts a vector this cycle.
REQ-007 in_data  input  N_LANES*DATA_WIDTH  input vector; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 in_last  input  1  marks the final vector of a tile; sampled with the in_valid&in_ready transfer.
REQ-009 out_data  output  N_LANES*DATA_WIDTH  skewed lanes; lane i drives the input_data port of array row i.
REQ-010 out_lane_valid  output  N_LANES  per-lane element valid.
REQ-011 out_done  output  1  one-cycle pulse when the final element of a tile leaves lane N_LANES-1.
REQ-012 busy  output  1  high while state is not IDLE.

Function
REQ-013 A transfer occurs on a cycle when in_valid and in_ready are both high.
REQ-014 FSM states are IDLE, STREAM and DRAIN.
REQ-015 IDLE: in_ready=1; a transfer moves to STREAM, or to DRAIN if in_last=1 on that transfer.
REQ-016 STREAM: in_ready=1; a transfer with in_last=1 moves to DRAIN; otherwise the state remains STREAM.
REQ-017 DRAIN: in_ready=0; a drain counter counts N_LANES-1 cycles, then the FSM returns to IDLE.
REQ-018 When N_LANES=1, DRAIN lasts zero cycles: the FSM goes from the last transfer straight to IDLE.
REQ-019 Lane i of a transferred vector appears on out_data lane i exactly i+1 cycles after the transfer, with out_lane_valid[i]=1.
REQ-020 The delay lines shift every cycle unconditionally; no stall path exists.
REQ-021 A cycle without a transfer injects zero data with lane-valid 0 (a bubble) at the head of every lane.
REQ-022 Invalid lanes drive out_data lane = 0, so downstream MACs add zero.
REQ-023 out_done=1 on the cycle when lane N_LANES-1 presents the element from the in_last vector.
REQ-024 out_done follows that in_last transfer by exactly N_LANES cycles.
REQ-025 In IDLE, a new tile's first vector is accepted on the same cycle the FSM re-enters IDLE.
REQ-026 A new tile's elements may overlap the previous tile's tail in the lanes.
REQ-027 Data passes through unmodified; there is no arithmetic and no width change.

Reset
REQ-028 rst=1 for one clk edge sets state=IDLE and the drain counter=0.
REQ-029 rst clears all delay-line data and lane-valid bits to 0 and sets out_done=0.
REQ-030 During and after reset, out_data=0, out_lane_valid=0, out_done=0, busy=0 and in_ready=1.
REQ-031 rst asserted mid-tile discards all in-flight elements; no out_done is produced for that tile.

Structure
REQ-032 Package systolic_pkg holds the FSM state enum (IDLE, STREAM, DRAIN) and the default DATA_WIDTH and N_LANES constants.
REQ-033 systolic_pkg is shared with the PE array.
REQ-034 Sub-module systolic_delay_line, parameterised by DEPTH and WIDTH, is a register chain with synchronous active-high reset.
REQ-035 One systolic_delay_line instance per lane, DEPTH=i+1, carries {valid, data}.
REQ-036 The drain counter width is $clog2(N_LANES) bits, minimum 1.

Verification (N_LANES=4, DATA_WIDTH=8)
REQ-037 Reset: hold rst 2 cycles -> all outputs 0, in_ready=1, busy=0.
REQ-038 Single vector {lane3..0}={0x44,0x33,0x22,0x11} with in_last at t0 -> outputs:
- lane0=0x11 at t1
- lane1=0x22 at t2
- lane2=0x33 at t3
- lane3=0x44 at t4
- out_done at t4
- in_ready=0 during t1..t3
- in_ready=1 at t4
REQ-039 Three back-to-back vectors A,B,C (C last) -> lane2 shows A,B,C on consecutive cycles t3,t4,t5; out_done at t6.
REQ-040 Vector A, one idle cycle, vector B (last) -> every lane shows a bubble between A and B (valid=0, data=0).
REQ-041 rst asserted 2 cycles after the first transfer of a 3-vector tile -> all lane-valids are 0 on the next cycle and out_done never pulses.
REQ-042 Tile X ends, then tile Y's first vector is offered with in_valid held high -> Y is accepted exactly on the IDLE re-entry cycle, and lanes show X's tail overlapping Y's head with no corruption.
